// File: rtl/dma_axil_wr_arbiter_pkg.sv
// Shared encodings for the DMA AXI-Lite write arbiter: FSM states, watchdog width, BRESP codes.
// Imported by the arbiter top and reusable by the sibling read/response arbiters.
package dma_axil_wr_arbiter_pkg;

  localparam int DMA_ARB_WR_FSM_WIDTH = 2;
  localparam int AXIL_CNT_WIDTH       = 8;

  typedef enum logic [DMA_ARB_WR_FSM_WIDTH-1:0] {
    FSM_DMA_ARB_WR_IDLE     = 2'd0,
    FSM_DMA_ARB_WR_CH0      = 2'd1,
    FSM_DMA_ARB_WR_CH1      = 2'd2,
    FSM_DMA_ARB_WR_ABORTING = 2'd3
  } dma_arb_wr_state_e;

  localparam logic [1:0] AXIL_BRESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_BRESP_SLVERR = 2'b10;

endpackage

// File: rtl/dma_axil_wr_arbiter_rr_arb2.sv
// Two-requester round-robin picker: combinational one-hot grant, pointer flips on contended grant when enabled.
// Zero-latency pick; the caller decides when a pick is consumed via i_en.
module dma_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    o_gnt = 2'b00;
    ptr_d = ptr_q;
    case (i_req)
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        // ptr_q = 0 favours ch0; the loser becomes the favourite next time
        o_gnt = ptr_q ? 2'b10 : 2'b01;
        if (i_en) ptr_d = ~ptr_q;
      end
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dma_axil_wr_arbiter.sv
// Round-robin arbiter of two DMA write channels onto one AXI-Lite master; grant one cycle after request,
// AW/W/B forwarded combinationally; abort drains outstanding master beats, swallows B, returns SLVERR.
module dma_axil_wr_arbiter
  import dma_axil_wr_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_abort,
  input  logic [ADDR_WIDTH-1:0]   i_ch0_awaddr,
  input  logic                    i_ch0_awvalid,
  output logic                    o_ch0_awready,
  input  logic [DATA_WIDTH-1:0]   i_ch0_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ch0_wstrb,
  input  logic                    i_ch0_wvalid,
  output logic                    o_ch0_wready,
  output logic [1:0]              o_ch0_bresp,
  output logic                    o_ch0_bvalid,
  input  logic                    i_ch0_bready,
  input  logic [ADDR_WIDTH-1:0]   i_ch1_awaddr,
  input  logic                    i_ch1_awvalid,
  output logic                    o_ch1_awready,
  input  logic [DATA_WIDTH-1:0]   i_ch1_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_ch1_wstrb,
  input  logic                    i_ch1_wvalid,
  output logic                    o_ch1_wready,
  output logic [1:0]              o_ch1_bresp,
  output logic                    o_ch1_bvalid,
  input  logic                    i_ch1_bready,
  output logic [ADDR_WIDTH-1:0]   o_m_awaddr,
  output logic                    o_m_awvalid,
  input  logic                    i_m_awready,
  output logic [DATA_WIDTH-1:0]   o_m_wdata,
  output logic [DATA_WIDTH/8-1:0] o_m_wstrb,
  output logic                    o_m_wvalid,
  input  logic                    i_m_wready,
  input  logic [1:0]              i_m_bresp,
  input  logic                    i_m_bvalid,
  output logic                    o_m_bready,
  output logic [1:0]              o_grant,
  output logic                    o_busy,
  output logic                    o_abort_done,
  output logic                    o_timeout
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [AXIL_CNT_WIDTH-1:0] CNT_TIMEOUT = AXIL_CNT_WIDTH'(TIMEOUT);

  dma_arb_wr_state_e           state_q, state_d;
  logic [1:0]                  gnt_q, gnt_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic [AXIL_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]                  err_pend_q, err_pend_d;
  logic                        abort_done_q, abort_done_d;
  logic                        timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0]       lat_awaddr_q, lat_awaddr_d;
  logic [DATA_WIDTH-1:0]       lat_wdata_q, lat_wdata_d;
  logic [STRB_WIDTH-1:0]       lat_wstrb_q, lat_wstrb_d;

  logic                        sel_awvalid, sel_wvalid, sel_bready;
  logic [ADDR_WIDTH-1:0]       sel_awaddr;
  logic [DATA_WIDTH-1:0]       sel_wdata;
  logic [STRB_WIDTH-1:0]       sel_wstrb;
  logic                        fwd_awready, fwd_wready, fwd_bvalid;
  logic                        aw_hs, w_hs, b_hs;
  logic [1:0]                  arb_req, arb_gnt;
  logic                        arb_en;

  // A channel still owed an abort SLVERR must collect it before it can win again
  assign arb_req = {i_ch1_awvalid & ~err_pend_q[1], i_ch0_awvalid & ~err_pend_q[0]};

  dma_rr_arb2 u_rr_arb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (arb_req),
    .i_en    (arb_en),
    .o_gnt   (arb_gnt)
  );

  always_comb begin
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    sel_awaddr  = '0;
    sel_wdata   = '0;
    sel_wstrb   = '0;
    if (gnt_q[0]) begin
      sel_awvalid = i_ch0_awvalid;
      sel_wvalid  = i_ch0_wvalid;
      sel_bready  = i_ch0_bready;
      sel_awaddr  = i_ch0_awaddr;
      sel_wdata   = i_ch0_wdata;
      sel_wstrb   = i_ch0_wstrb;
    end else if (gnt_q[1]) begin
      sel_awvalid = i_ch1_awvalid;
      sel_wvalid  = i_ch1_wvalid;
      sel_bready  = i_ch1_bready;
      sel_awaddr  = i_ch1_awaddr;
      sel_wdata   = i_ch1_wdata;
      sel_wstrb   = i_ch1_wstrb;
    end
  end

  always_comb begin
    o_m_awvalid = 1'b0;
    o_m_awaddr  = '0;
    o_m_wvalid  = 1'b0;
    o_m_wdata   = '0;
    o_m_wstrb   = '0;
    o_m_bready  = 1'b0;
    fwd_awready = 1'b0;
    fwd_wready  = 1'b0;
    fwd_bvalid  = 1'b0;
    case (state_q)
      FSM_DMA_ARB_WR_CH0, FSM_DMA_ARB_WR_CH1: begin
        o_m_awvalid = sel_awvalid & ~aw_done_q;
        o_m_awaddr  = sel_awaddr;
        o_m_wvalid  = sel_wvalid & ~w_done_q;
        o_m_wdata   = sel_wdata;
        o_m_wstrb   = sel_wstrb;
        fwd_awready = i_m_awready & ~aw_done_q;
        fwd_wready  = i_m_wready & ~w_done_q;
        fwd_bvalid  = i_m_bvalid & aw_done_q & w_done_q;
        o_m_bready  = sel_bready & aw_done_q & w_done_q;
      end
      FSM_DMA_ARB_WR_ABORTING: begin
        // Beats already offered to the master are held from the latch until accepted
        o_m_awvalid = ~aw_done_q;
        o_m_awaddr  = lat_awaddr_q;
        o_m_wvalid  = ~w_done_q;
        o_m_wdata   = lat_wdata_q;
        o_m_wstrb   = lat_wstrb_q;
        o_m_bready  = aw_done_q & w_done_q;
      end
      default: ;
    endcase
  end

  assign aw_hs = o_m_awvalid & i_m_awready;
  assign w_hs  = o_m_wvalid & i_m_wready;
  assign b_hs  = i_m_bvalid & o_m_bready;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    aw_done_d    = aw_done_q | aw_hs;
    w_done_d     = w_done_q | w_hs;
    cnt_d        = '0;
    err_pend_d   = err_pend_q & ~{i_ch1_bready, i_ch0_bready};
    abort_done_d = 1'b0;
    timeout_d    = 1'b0;
    lat_awaddr_d = lat_awaddr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_wstrb_d  = lat_wstrb_q;
    arb_en       = 1'b0;
    case (state_q)
      FSM_DMA_ARB_WR_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (!i_abort && (arb_gnt != 2'b00)) begin
          arb_en  = 1'b1;
          gnt_d   = arb_gnt;
          state_d = arb_gnt[0] ? FSM_DMA_ARB_WR_CH0 : FSM_DMA_ARB_WR_CH1;
        end
      end
      FSM_DMA_ARB_WR_CH0, FSM_DMA_ARB_WR_CH1: begin
        if (b_hs) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          gnt_d     = 2'b00;
          state_d   = FSM_DMA_ARB_WR_IDLE;
        end else if (i_abort) begin
          // A beat the channel never offered is treated as done: nothing to drain
          aw_done_d    = aw_done_q | aw_hs | ~sel_awvalid;
          w_done_d     = w_done_q | w_hs | ~sel_wvalid;
          lat_awaddr_d = sel_awaddr;
          lat_wdata_d  = sel_wdata;
          lat_wstrb_d  = sel_wstrb;
          state_d      = FSM_DMA_ARB_WR_ABORTING;
        end
      end
      FSM_DMA_ARB_WR_ABORTING: begin
        cnt_d = cnt_q + 1'b1;
        if (b_hs || (cnt_d == CNT_TIMEOUT)) begin
          state_d      = FSM_DMA_ARB_WR_IDLE;
          gnt_d        = 2'b00;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          cnt_d        = '0;
          abort_done_d = 1'b1;
          timeout_d    = ~b_hs;
          err_pend_d   = err_pend_d | gnt_q;
        end
      end
      default: begin
        state_d   = FSM_DMA_ARB_WR_IDLE;
        gnt_d     = 2'b00;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= FSM_DMA_ARB_WR_IDLE;
      gnt_q        <= 2'b00;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      cnt_q        <= '0;
      err_pend_q   <= 2'b00;
      abort_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      lat_awaddr_q <= '0;
      lat_wdata_q  <= '0;
      lat_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      cnt_q        <= cnt_d;
      err_pend_q   <= err_pend_d;
      abort_done_q <= abort_done_d;
      timeout_q    <= timeout_d;
      lat_awaddr_q <= lat_awaddr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_wstrb_q  <= lat_wstrb_d;
    end
  end

  assign o_ch0_awready = gnt_q[0] & fwd_awready;
  assign o_ch0_wready  = gnt_q[0] & fwd_wready;
  assign o_ch0_bvalid  = (gnt_q[0] & fwd_bvalid) | err_pend_q[0];
  assign o_ch0_bresp   = err_pend_q[0] ? AXIL_BRESP_SLVERR :
                         (gnt_q[0] & fwd_bvalid) ? i_m_bresp : AXIL_BRESP_OKAY;
  assign o_ch1_awready = gnt_q[1] & fwd_awready;
  assign o_ch1_wready  = gnt_q[1] & fwd_wready;
  assign o_ch1_bvalid  = (gnt_q[1] & fwd_bvalid) | err_pend_q[1];
  assign o_ch1_bresp   = err_pend_q[1] ? AXIL_BRESP_SLVERR :
                         (gnt_q[1] & fwd_bvalid) ? i_m_bresp : AXIL_BRESP_OKAY;

  assign o_grant      = gnt_q;
  assign o_busy       = (state_q != FSM_DMA_ARB_WR_IDLE);
  assign o_abort_done = abort_done_q;
  assign o_timeout    = timeout_q;

endmodule

// File: doc/dma_axil_wr_arbiter.md
Name: dma_axil_wr_arbiter

Overview:
- Arbitrates two DMA channel write requesters (ch0, ch1) onto one shared AXI-Lite master write port (AW, W, B).
- Grants one channel per transaction with round-robin fairness and routes the B response back to the granted channel.
- Provides a controlled abort/drain path with a response watchdog; sits between the DMA channel FSMs and the AXI-Lite interconnect.
- FSM uses the shared DMA_ARB_WR encoding: IDLE, CH0, CH1, ABORTING.

Parameters:
- ADDR_WIDTH, 32, AW address width.
- DATA_WIDTH, 32, W data width; strobe width is DATA_WIDTH/8.
- TIMEOUT, 255, cycles to wait for the B response in ABORTING; must fit in AXIL_CNT_WIDTH.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset. One clock domain; reset polarity and synchronicity are fixed.
- i_abort  in  1  level request to abort; sampled each cycle.
- i_chN_awaddr  in  ADDR_WIDTH  channel N write address (N = 0, 1).
- i_chN_awvalid / o_chN_awready  in/out  1  channel N AW handshake.
- i_chN_wdata  in  DATA_WIDTH  channel N write data.
- i_chN_wstrb  in  DATA_WIDTH/8  channel N write strobes.
- i_chN_wvalid / o_chN_wready  in/out  1  channel N W handshake.
- o_chN_bresp  out  2  response returned to channel N.
- o_chN_bvalid / i_chN_bready  out/in  1  channel N B handshake.
- o_m_awaddr  out  ADDR_WIDTH  master write address.
- o_m_awvalid / i_m_awready  out/in  1  master AW handshake.
- o_m_wdata  out  DATA_WIDTH  master write data.
- o_m_wstrb  out  DATA_WIDTH/8  master write strobes.
- o_m_wvalid / i_m_wready  out/in  1  master W handshake.
- i_m_bresp  in  2  master write response.
- i_m_bvalid / o_m_bready  in/out  1  master B handshake.
- o_grant  out  2  one-hot grant: bit0 = ch0, bit1 = ch1.
- o_busy  out  1  high whenever state is not IDLE.
- o_abort_done  out  1  one-cycle pulse when ABORTING exits.
- o_timeout  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset: state IDLE, o_grant = 0, priority pointer = ch0, aw_done = w_done = 0, counter = 0.
- Reset: all valid/ready outputs 0, o_busy = o_abort_done = o_timeout = 0. Data outputs are 0 when nothing is granted.
- Reset mid-transaction: drop to IDLE immediately, with no drain.
- Request: a channel requests when i_chN_awvalid = 1.
- IDLE: if i_abort = 0, grant is registered one cycle after a request is seen.
  - Only one requester: that channel is granted.
  - Both request: grant the priority channel, then flip the pointer to the other channel.
  - i_abort = 1 in IDLE: no grant; stay IDLE.
- CH0/CH1 forwarding is combinational through a mux on the grant:
  - m_awvalid = chN_awvalid & ~aw_done; chN_awready = m_awready & ~aw_done.
  - W is forwarded the same way, gated by w_done.
  - aw_done and w_done set on their respective handshakes; AW and W may complete in either order or in the same cycle.
  - After both are done, m_bvalid/bresp are forwarded to chN and m_bready = chN_bready.
  - On the B handshake: clear the flags and return to IDLE. The non-granted channel sees all readies and bvalid at 0.
- i_abort in CH0/CH1 moves the FSM to ABORTING next cycle:
  - Master AW/W already asserted stay asserted with the latched data until accepted (AXI: no valid retraction). The latch is captured on entry.
  - Channel readies are forced to 0.
  - Once AW and W are done, m_bready = 1 and the B is swallowed.
  - On that B: pulse o_abort_done, return to IDLE.
  - The granted channel receives o_chN_bvalid = 1 with bresp = 2'b10 (SLVERR) for one handshake, issued on ABORTING exit and held until i_chN_bready.
- Watchdog: an AXIL_CNT_WIDTH counter increments every cycle in ABORTING and clears on exit.
  - Reaching TIMEOUT: pulse o_timeout and o_abort_done, clear state, return to IDLE.
- Simultaneous events: i_abort on the same cycle as the final B handshake completes normally (the B wins) and no abort is taken.
- Unused encoding (state 3 reached other than via abort) is impossible; default branch returns to IDLE.

Decomposition:
- Shared package: DMA_ARB_WR_FSM_WIDTH, the FSM_DMA_ARB_WR_* state constants, AXIL_CNT_WIDTH, and the BRESP constants OKAY = 2'b00, SLVERR = 2'b10 (to be added).
- Sub-module: dma_rr_arb2, a two-requester round-robin picker with pointer update enable. It is reusable by the read and response arbiters.

Test Plan:
- Single write: ch0 awaddr 0x100, wdata 0xDEADBEEF, strb 0xF → o_grant = 01 one cycle later; master sees identical AW/W; m_bresp 00 reaches ch0; FSM returns to IDLE; o_busy = 0.
- Contention: ch0 and ch1 request in the same cycle, 3 transactions each → grants alternate ch0, ch1, ch0, ch1, ch0, ch1; no channel is starved.
- Split handshake: m_wready asserted 3 cycles before m_awready → W not re-presented after its handshake; B forwarded only after both are done.
- Abort during access: i_abort with AW accepted but W pending → W stays valid with the same data until accepted; B swallowed; o_abort_done pulses; ch gets bresp = 10.
- Watchdog: abort with the master never asserting bvalid, TIMEOUT = 16 → o_timeout and o_abort_done pulse 16 cycles after entering ABORTING; state IDLE.
- Synchronous reset asserted while in CH1 → next cycle o_grant = 0, all valids 0, pointer = ch0.
